// File: rtl/imm_pkg.sv
// imm_pkg: shared types for the immediate-generation stage.
// Format-select encodings, occupancy states and parameter checks.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I  = 3'b000,
        IMM_S  = 3'b001,
        IMM_B  = 3'b010,
        IMM_J  = 3'b011,
        IMM_U  = 3'b100,
        IMM_Z  = 3'b101,
        IMM_R6 = 3'b110,
        IMM_R7 = 3'b111
    } immsrc_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'b00,
        OCC_ONE   = 2'b01,
        OCC_TWO   = 2'b10
    } occ_t;

    localparam int XLEN_NARROW = 32;
    localparam int XLEN_WIDE   = 64;

    function automatic bit xlen_legal(input int x);
        return (x == XLEN_NARROW) || (x == XLEN_WIDE);
    endfunction

endpackage

// File: rtl/imm_gen_stage_core.sv
// imm_ext_core: combinational immediate extraction and extension.
// Maps instr[31:7] and a format select to an XLEN-wide immediate.
import imm_pkg::*;

module imm_ext_core #(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    input  logic [2:0]      immsrc,
    output logic [XLEN-1:0] immext,
    output logic            illegal
);

    immsrc_t     src;
    logic [11:0] imm_i;
    logic [11:0] imm_s;
    logic [12:0] imm_b;
    logic [20:0] imm_j;
    logic [31:0] imm_u;
    logic [4:0]  zimm;

    assign src   = immsrc_t'(immsrc);
    assign imm_i = instr[31:20];
    assign imm_s = {instr[31:25], instr[11:7]};
    assign imm_b = {instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};
    assign imm_j = {instr[31], instr[19:12], instr[20],
                    instr[30:21], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign zimm  = instr[19:15];

    // Select the format; reserved codes give zero and raise illegal.
    always_comb begin
        immext  = '0;
        illegal = 1'b0;
        unique case (src)
            IMM_I:   immext = XLEN'($signed(imm_i));
            IMM_S:   immext = XLEN'($signed(imm_s));
            IMM_B:   immext = XLEN'($signed(imm_b));
            IMM_J:   immext = XLEN'($signed(imm_j));
            IMM_U:   immext = XLEN'($signed(imm_u));
            IMM_Z:   immext = XLEN'(zimm);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered immediate generator with a 2-entry skid.
// Valid/ready on both sides, FIFO order, synchronous flush and reset.
import imm_pkg::*;

module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      in_instr,
    input  logic [2:0]       in_immsrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_immext,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("imm_gen_stage: XLEN must be 32 or 64");
    end

    occ_t             state;
    logic [XLEN-1:0]  ext_data;
    logic             ext_illegal;
    logic [XLEN-1:0]  skid_data;
    logic             skid_illegal;
    logic [TAG_W-1:0] skid_tag;
    logic             acc;
    logic             pop;

    imm_ext_core #(
        .XLEN (XLEN)
    ) u_core (
        .instr   (in_instr),
        .immsrc  (in_immsrc),
        .immext  (ext_data),
        .illegal (ext_illegal)
    );

    assign acc = in_valid & in_ready;
    assign pop = out_valid & out_ready;

    // Occupancy FSM; main entry drives out_*, skid catches the overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= OCC_EMPTY;
            out_valid    <= 1'b0;
            in_ready     <= 1'b1;
            out_immext   <= '0;
            out_illegal  <= 1'b0;
            out_tag      <= '0;
            skid_data    <= '0;
            skid_illegal <= 1'b0;
            skid_tag     <= '0;
        end else if (flush) begin
            state     <= OCC_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            unique case (state)
                OCC_EMPTY: begin
                    if (acc) begin
                        out_immext  <= ext_data;
                        out_illegal <= ext_illegal;
                        out_tag     <= in_tag;
                        out_valid   <= 1'b1;
                        state       <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    unique case (1'b1)
                        (acc & pop): begin
                            out_immext  <= ext_data;
                            out_illegal <= ext_illegal;
                            out_tag     <= in_tag;
                        end
                        (acc & ~pop): begin
                            skid_data    <= ext_data;
                            skid_illegal <= ext_illegal;
                            skid_tag     <= in_tag;
                            in_ready     <= 1'b0;
                            state        <= OCC_TWO;
                        end
                        (pop & ~acc): begin
                            out_valid <= 1'b0;
                            state     <= OCC_EMPTY;
                        end
                        default: ;
                    endcase
                end
                OCC_TWO: begin
                    if (pop) begin
                        out_immext  <= skid_data;
                        out_illegal <= skid_illegal;
                        out_tag     <= skid_tag;
                        in_ready    <= 1'b1;
                        state       <= OCC_ONE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= OCC_EMPTY;
                end
            endcase
        end
    end

endmodule
